// File: rtl/fft_frame_ctrl.sv
// Avalon-ST sink-side frame generator for the FFT core: sop/eop/valid framing,
// backpressure-safe read index, burst/continuous runs and optional inter-frame gap.
module fft_frame_ctrl #(
   parameter int MAX_LOG2N = 10,
   parameter int GAP       = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           cfg_log2n,
   input  logic                 cfg_inverse,
   input  logic [7:0]           cfg_frames,
   input  logic                 stop,
   input  logic                 sink_ready,
   output logic                 sink_valid,
   output logic                 sink_sop,
   output logic                 sink_eop,
   output logic                 sink_inverse,
   output logic [MAX_LOG2N-1:0] rd_addr,
   output logic                 busy,
   output logic                 frame_done,
   output logic [7:0]           frame_cnt,
   output logic                 cfg_err
);

   localparam int AW = MAX_LOG2N;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [3:0]    LOG2N_MAX = 4'(MAX_LOG2N);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      log2n_q, log2n_nxt;
   logic [7:0]      frames_q, frames_nxt;
   logic            stop_pend, stop_pend_nxt;
   logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
   logic            valid_nxt, sop_nxt, eop_nxt, inv_nxt, busy_nxt;
   logic            done_nxt, err_nxt;
   logic [AW-1:0]   addr_nxt, addr_inc, last_idx;
   logic [7:0]      cnt_nxt, cnt_inc;
   logic            xfer, cfg_legal, run_over;

   assign xfer      = sink_valid & sink_ready;
   assign cfg_legal = (cfg_log2n >= 4'd3) && (cfg_log2n <= LOG2N_MAX);
   assign last_idx  = {AW{1'b1}} >> (LOG2N_MAX - log2n_q);
   assign addr_inc  = rd_addr + 1'b1;
   assign cnt_inc   = frame_cnt + 8'd1;
   // A stop arriving together with the final beat still ends the run after that frame.
   assign run_over  = stop_pend | stop | ((frames_q != 8'd0) && (cnt_inc == frames_q));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         log2n_q      <= 4'd0;
         frames_q     <= 8'd0;
         stop_pend    <= 1'b0;
         gap_cnt      <= '0;
         sink_valid   <= 1'b0;
         sink_sop     <= 1'b0;
         sink_eop     <= 1'b0;
         sink_inverse <= 1'b0;
         rd_addr      <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         frame_cnt    <= 8'd0;
         cfg_err      <= 1'b0;
      end else begin
         state        <= state_nxt;
         log2n_q      <= log2n_nxt;
         frames_q     <= frames_nxt;
         stop_pend    <= stop_pend_nxt;
         gap_cnt      <= gap_cnt_nxt;
         sink_valid   <= valid_nxt;
         sink_sop     <= sop_nxt;
         sink_eop     <= eop_nxt;
         sink_inverse <= inv_nxt;
         rd_addr      <= addr_nxt;
         busy         <= busy_nxt;
         frame_done   <= done_nxt;
         frame_cnt    <= cnt_nxt;
         cfg_err      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      log2n_nxt     = log2n_q;
      frames_nxt    = frames_q;
      stop_pend_nxt = stop_pend;
      gap_cnt_nxt   = gap_cnt;
      valid_nxt     = sink_valid;
      sop_nxt       = sink_sop;
      eop_nxt       = sink_eop;
      inv_nxt       = sink_inverse;
      addr_nxt      = rd_addr;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      cnt_nxt       = frame_cnt;
      err_nxt       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               if (cfg_legal) begin
                  state_nxt     = S_STREAM;
                  log2n_nxt     = cfg_log2n;
                  frames_nxt    = cfg_frames;
                  inv_nxt       = cfg_inverse;
                  stop_pend_nxt = 1'b0;
                  cnt_nxt       = 8'd0;
                  addr_nxt      = '0;
                  valid_nxt     = 1'b1;
                  sop_nxt       = 1'b1;
                  eop_nxt       = 1'b0;
                  busy_nxt      = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end

         S_STREAM: begin
            if (stop)
               stop_pend_nxt = 1'b1;
            if (xfer) begin
               if (sink_eop) begin
                  done_nxt = 1'b1;
                  cnt_nxt  = cnt_inc;
                  addr_nxt = '0;
                  eop_nxt  = 1'b0;
                  if (run_over) begin
                     state_nxt     = S_IDLE;
                     valid_nxt     = 1'b0;
                     sop_nxt       = 1'b0;
                     busy_nxt      = 1'b0;
                     stop_pend_nxt = 1'b0;
                  end else if (GAP > 0) begin
                     state_nxt   = S_GAP;
                     valid_nxt   = 1'b0;
                     sop_nxt     = 1'b0;
                     gap_cnt_nxt = '0;
                  end else begin
                     sop_nxt = 1'b1;
                  end
               end else begin
                  addr_nxt = addr_inc;
                  sop_nxt  = 1'b0;
                  eop_nxt  = (addr_inc == last_idx);
               end
            end
         end

         S_GAP: begin
            if (stop)
               stop_pend_nxt = 1'b1;
            if (gap_cnt == GAP_LAST) begin
               // A stop seen during the gap ends the run instead of opening a new frame.
               if (stop_pend | stop) begin
                  state_nxt     = S_IDLE;
                  busy_nxt      = 1'b0;
                  stop_pend_nxt = 1'b0;
               end else begin
                  state_nxt = S_STREAM;
                  valid_nxt = 1'b1;
                  sop_nxt   = 1'b1;
                  addr_nxt  = '0;
               end
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: expected beats and frame_done counts are queued
// by the stimulus, a negedge monitor pops them on each transfer / frame_done pulse.
module tb_fft_frame_ctrl;

   localparam int ML = 10;
   localparam int G  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    cfg_log2n = 4'd3;
   logic          cfg_inverse = 1'b0;
   logic [7:0]    cfg_frames = 8'd1;
   logic          stop = 1'b0;
   logic          sink_ready = 1'b1;
   logic          sink_valid, sink_sop, sink_eop, sink_inverse;
   logic [ML-1:0] rd_addr;
   logic          busy, frame_done, cfg_err;
   logic [7:0]    frame_cnt;

   fft_frame_ctrl #(.MAX_LOG2N(ML), .GAP(G)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_log2n(cfg_log2n),
      .cfg_inverse(cfg_inverse), .cfg_frames(cfg_frames), .stop(stop),
      .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_inverse(sink_inverse), .rd_addr(rd_addr),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ML-1:0] addr;
      logic          sop;
      logic          eop;
      logic          inv;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] fd_q[$];
   int         checks = 0;
   int         errors = 0;
   int         fd_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input int log2n, input logic inv);
      for (int b = 0; b < (1 << log2n); b++)
         exp_q.push_back('{addr: ML'(b), sop: (b == 0), eop: (b == (1 << log2n) - 1), inv: inv});
   endtask

   // Monitor: every transfer and every frame_done pulse is matched against the queues.
   always @(negedge clk) begin
      if (reset) begin
         if (sink_valid && sink_ready) begin
            if (exp_q.size() == 0)
               check("xfer_unexpected", {63'd0, sink_valid}, 64'd0);
            else
               check("beat", {rd_addr, sink_sop, sink_eop, sink_inverse}, exp_q.pop_front());
         end
         if (frame_done) begin
            fd_seen++;
            if (fd_q.size() == 0)
               check("frame_done_unexpected", {63'd0, frame_done}, 64'd0);
            else
               check("frame_cnt_at_done", frame_cnt, fd_q.pop_front());
         end
      end
   end

   task automatic pulse_start(input logic [3:0] l2n, input logic inv, input logic [7:0] frames);
      cfg_log2n = l2n; cfg_inverse = inv; cfg_frames = frames; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_timeout"}, {63'd0, busy}, 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] act_v, exp_v, act_b, exp_b;
      logic [12:0] held;
      bit          stalled [8];
      bit          was_stall;
      int          cyc;

      // Reset state
      #1 reset = 1'b0;
      #2;
      check("reset_outputs", {sink_valid, sink_sop, sink_eop, sink_inverse, rd_addr,
                              busy, frame_done, frame_cnt, cfg_err}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // Single 8-beat frame
      push_frame(3, 1'b0); fd_q.push_back(8'd1);
      pulse_start(4'd3, 1'b0, 8'd1);
      check("t1_first_beat", {sink_valid, sink_sop, busy, rd_addr}, {3'b111, 10'd0});
      wait_idle("t1");
      check("t1_final", {frame_cnt, busy, sink_valid}, {8'd1, 2'b00});
      check("t1_queue_empty", exp_q.size(), 0);

      // Three 16-beat frames with 2-cycle gap, cycle-exact valid/busy pattern
      for (int f = 0; f < 3; f++) begin
         push_frame(4, 1'b0);
         fd_q.push_back(8'(f + 1));
      end
      pulse_start(4'd4, 1'b0, 8'd3);
      act_v = '0; exp_v = '0; act_b = '0; exp_b = '0;
      for (int i = 0; i < 53; i++) begin
         @(negedge clk);
         act_v[i] = sink_valid;
         act_b[i] = busy;
         exp_v[i] = (i < 52) && !(i == 16 || i == 17 || i == 34 || i == 35);
         exp_b[i] = (i < 52);
      end
      check("t2_valid_pattern", act_v, exp_v);
      check("t2_busy_pattern", act_b, exp_b);
      wait_idle("t2");
      check("t2_frame_cnt", frame_cnt, 8'd3);

      // Backpressure on beats 0, 3 and 7
      push_frame(3, 1'b0); fd_q.push_back(8'd1);
      stalled = '{default: 1'b0};
      was_stall = 1'b0;
      held = '0;
      cyc = 0;
      pulse_start(4'd3, 1'b0, 8'd1);
      while (busy && cyc < 60) begin
         if (was_stall)
            check("bp_hold", {rd_addr, sink_sop, sink_eop, sink_valid}, held);
         was_stall = 1'b0;
         if (sink_valid && (rd_addr inside {10'd0, 10'd3, 10'd7}) && !stalled[rd_addr[2:0]]) begin
            sink_ready = 1'b0;
            stalled[rd_addr[2:0]] = 1'b1;
            was_stall = 1'b1;
            held = {rd_addr, sink_sop, sink_eop, sink_valid};
         end else begin
            sink_ready = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      sink_ready = 1'b1;
      check("bp_cycles", cyc, 11);
      check("bp_stalls", {stalled[0], stalled[3], stalled[7]}, 3'b111);
      wait_idle("t3");

      // Continuous run, inverse, start-while-busy ignored, stop in frame 2 beat 5
      for (int f = 0; f < 3; f++) begin
         push_frame(3, 1'b1);
         fd_q.push_back(8'(f + 1));
      end
      fd_seen = 0;
      pulse_start(4'd3, 1'b1, 8'd0);
      repeat (2) begin @(posedge clk); #1; end
      pulse_start(4'd5, 1'b0, 8'd1);
      cyc = 0;
      while (!(fd_seen == 2 && sink_valid && rd_addr == 10'd5) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("t4_reach_stop_point", {sink_valid, rd_addr, sink_inverse}, {1'b1, 10'd5, 1'b1});
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_idle("t4");
      check("t4_frame_cnt", frame_cnt, 8'd3);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("t4_stop_in_idle", {busy, sink_valid, frame_cnt}, {2'b00, 8'd3});

      // Illegal frame lengths
      for (int k = 0; k < 2; k++) begin
         logic [3:0] bad;
         bad = (k == 0) ? 4'd2 : 4'(ML + 1);
         pulse_start(bad, 1'b0, 8'd1);
         check("cfg_err_pulse", {cfg_err, busy, sink_valid}, 3'b100);
         @(posedge clk); #1;
         check("cfg_err_after", {cfg_err, busy, sink_valid}, 3'b000);
      end

      // Async reset at beat 10 of a 16-beat frame, then a fresh run
      for (int b = 0; b < 10; b++)
         exp_q.push_back('{addr: ML'(b), sop: (b == 0), eop: 1'b0, inv: 1'b0});
      pulse_start(4'd4, 1'b0, 8'd1);
      repeat (10) begin @(posedge clk); #1; end
      check("t6_at_beat10", {sink_valid, rd_addr}, {1'b1, 10'd10});
      reset = 1'b0;
      #1;
      check("t6_reset_outputs", {sink_valid, sink_sop, sink_eop, sink_inverse, rd_addr,
                                 busy, frame_done, frame_cnt, cfg_err}, 64'd0);
      check("t6_queue_empty", exp_q.size(), 0);
      @(posedge clk); #1 reset = 1'b1;
      push_frame(3, 1'b0); fd_q.push_back(8'd1);
      pulse_start(4'd3, 1'b0, 8'd1);
      check("t6_restart", {sink_valid, sink_sop, rd_addr}, {2'b11, 10'd0});
      wait_idle("t6");

      check("final_beat_queue", exp_q.size(), 0);
      check("final_done_queue", fd_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
